dmem_io_responder: RTL
======================

# dmem_io_responder

Data-side responder for the 8-bit pipelined CPU: it answers the CPU's data-memory accesses and serves memory-mapped I/O. It contains a 240-byte data RAM, the two display output registers, and a small keyboard receive FIFO with a status register. It connects directly to the CPU's `Address_DM` / `Data_out_DM` / `Data_in_DM` ports and to the board keyboard and display pins.

## Interface
Parameters:
- `KB_DEPTH_LOG2`, default 2: keyboard FIFO depth is 2^KB_DEPTH_LOG2 entries (4).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `Address_DM`  in  8  CPU data address.
- `Data_out_DM`  in  8  CPU write data.
- `MW`  in  1  memory write enable from the CPU.
- `MR`  in  1  memory read strobe from the CPU; high for the cycle a load is in execute.
- `Data_in_DM`  out  8  read data to the CPU; combinational from `Address_DM`.
- `KB`  in  8  keyboard byte.
- `kb_valid`  in  1  one-cycle strobe; `KB` is valid while this is high.
- `Output_LSB`  out  8  display low byte register.
- `Output_MSB`  out  8  display high byte register.
- `kb_irq`  out  1  high while the keyboard FIFO is non-empty (registered state, no extra delay).

## Operation
- Address map:
  - 0x00–0xEF: RAM.
  - 0xF0: OUT_LSB (R/W).
  - 0xF1: OUT_MSB (R/W).
  - 0xF2: KB_DATA (read pops the FIFO; writes ignored).
  - 0xF3: STATUS.
  - 0xF4–0xFF: read 0x00, writes ignored.
- STATUS register:
  - bit0 = FIFO not empty; bit1 = overflow (sticky); bit2 = FIFO full; bits7:3 = 0.
  - Writing a value with bit1=1 to 0xF3 clears overflow. Other bits are read-only.
- Reads are combinational.
  - `Data_in_DM` always reflects the current address and current state, independent of `MR`.
  - KB_DATA on an empty FIFO reads 0x00.
- Pop occurs at the edge when `MR` & `Address_DM`==0xF2 & FIFO not empty.
- Push occurs at the edge when `kb_valid` & (not full, or a pop occurs in the same cycle).
  - If `kb_valid` arrives while full and no pop occurs, the byte is dropped and overflow is set.
- FIFO pointers:
  - Read and write pointers wrap modulo 2^KB_DEPTH_LOG2.
  - Count is KB_DEPTH_LOG2+1 bits, range 0..depth.
- Simultaneous events:
  - Push and pop on a full FIFO: count unchanged, no overflow.
  - Push and pop on an empty FIFO: no pop (the read returns 0x00); the push is stored; count becomes 1.
  - Overflow-set and overflow-clear in the same cycle: set wins.
- `MW` and `MR` both high in one cycle: the write is performed, and the read side-effect (pop) is also performed if the address is 0xF2.
- RAM is write-first into storage but reads are combinational, so the written value appears on `Data_in_DM` the cycle after the write edge.

## Timing
- Reset (`rst` low, asynchronous):
  - `Output_LSB`=0x00, `Output_MSB`=0x00.
  - FIFO empty: pointers=0, count=0.
  - overflow=0, `kb_irq`=0.
  - `Data_in_DM` at 0xF3 reads 0x00.
- RAM contents are not reset (undefined until written).
- Reset asserted mid-operation discards FIFO contents and any write in that cycle.
- Release of reset is synchronous in effect: first state change on the first rising edge with `rst` high.
- Write latency: register and RAM updates take effect at the rising edge where `MW`=1; new value is visible on `Data_in_DM` and output pins immediately after that edge.
- Keyboard latency: a byte strobed at edge N is readable at 0xF2 and raises `kb_irq` after edge N.
- Read latency: 0 cycles (combinational). Pop side-effect is at the edge ending the `MR` cycle.

## Test plan
- Reset: hold `rst` low mid-run with FIFO holding 2 bytes and outputs set -> `Output_LSB`/`Output_MSB`=0x00, `kb_irq`=0, read 0xF3 = 0x00.
- RAM/regs: write 0x5A to 0x10, 0xA5 to 0xEF, 0x3C to 0xF0, 0xC3 to 0xF1.
  - Read back 0x10=0x5A and 0xEF=0xA5.
  - `Output_LSB`=0x3C and `Output_MSB`=0xC3 after the respective edges.
  - Write to 0xF5 then read -> 0x00.
- FIFO order: push 0x11, 0x22, 0x33 -> STATUS=0x01; three `MR` reads of 0xF2 return 0x11, 0x22, 0x33; then STATUS=0x00, fourth read=0x00 with no underflow.
- Overflow: push 5 bytes 0x01..0x05 -> STATUS=0x07, pops return 0x01..0x04; write 0x02 to 0xF3 -> bit1 clears.
- Simultaneous: full FIFO with push 0x99 and pop in the same cycle -> pop returns oldest byte, STATUS stays 0x05, 0x99 is the last byte out.
- Empty push+pop: same-cycle `kb_valid`(0x77) and pop on empty -> read 0x00, then next read 0x77.

Source files
------------

// File: rtl/dmem_io_responder.sv
// dmem_io_responder: data-side responder for the 8-bit pipelined CPU.
// Holds the 240-byte data RAM, the two display registers and a keyboard
// receive FIFO with a status register. Reads are combinational.
module dmem_io_responder #(
   parameter int unsigned KB_DEPTH_LOG2 = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] Address_DM,
   input  logic [7:0] Data_out_DM,
   input  logic       MW,
   input  logic       MR,
   output logic [7:0] Data_in_DM,
   input  logic [7:0] KB,
   input  logic       kb_valid,
   output logic [7:0] Output_LSB,
   output logic [7:0] Output_MSB,
   output logic       kb_irq
);

   localparam int unsigned DEPTH    = 1 << KB_DEPTH_LOG2;
   localparam int unsigned CNT_W    = KB_DEPTH_LOG2 + 1;
   localparam int unsigned RAM_SIZE = 240;

   localparam logic [7:0] ADDR_OUT_LSB = 8'hF0;
   localparam logic [7:0] ADDR_OUT_MSB = 8'hF1;
   localparam logic [7:0] ADDR_KB_DATA = 8'hF2;
   localparam logic [7:0] ADDR_STATUS  = 8'hF3;

   logic [7:0]               ram     [RAM_SIZE];
   logic [7:0]               kb_mem  [DEPTH];
   logic [KB_DEPTH_LOG2-1:0] rd_ptr;
   logic [KB_DEPTH_LOG2-1:0] wr_ptr;
   logic [CNT_W-1:0]         kb_count;
   logic                     overflow;

   logic is_ram_c;
   logic fifo_empty_c;
   logic fifo_full_c;
   logic pop_c;
   logic push_c;
   logic ovf_set_c;
   logic ovf_clr_c;

   // Access decode and FIFO event qualification
   always_comb begin
      is_ram_c     = (Address_DM < ADDR_OUT_LSB);
      fifo_empty_c = (kb_count == '0);
      fifo_full_c  = (kb_count == CNT_W'(DEPTH));
      pop_c        = MR && (Address_DM == ADDR_KB_DATA) && !fifo_empty_c;
      push_c       = kb_valid && (!fifo_full_c || pop_c);
      ovf_set_c    = kb_valid && fifo_full_c && !pop_c;
      ovf_clr_c    = MW && (Address_DM == ADDR_STATUS) && Data_out_DM[1];
   end

   assign kb_irq = !fifo_empty_c;

   // Data RAM: contents are never cleared, but a write landing during reset is dropped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
      end else if (MW && is_ram_c) begin
         ram[Address_DM] <= Data_out_DM;
      end
   end

   // Keyboard FIFO storage; stale entries are harmless since pointers reset
   always_ff @(posedge clk) begin
      if (push_c) begin
         kb_mem[wr_ptr] <= KB;
      end
   end

   // Display output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Output_LSB <= 8'h00;
         Output_MSB <= 8'h00;
      end else if (MW) begin
         if (Address_DM == ADDR_OUT_LSB) Output_LSB <= Data_out_DM;
         if (Address_DM == ADDR_OUT_MSB) Output_MSB <= Data_out_DM;
      end
   end

   // FIFO pointers, occupancy and sticky overflow (set beats clear)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         kb_count <= '0;
         overflow <= 1'b0;
      end else begin
         if (pop_c)  rd_ptr <= rd_ptr + KB_DEPTH_LOG2'(1);
         if (push_c) wr_ptr <= wr_ptr + KB_DEPTH_LOG2'(1);
         case ({push_c, pop_c})
            2'b10:   kb_count <= kb_count + CNT_W'(1);
            2'b01:   kb_count <= kb_count - CNT_W'(1);
            default: kb_count <= kb_count;
         endcase
         if (ovf_set_c)      overflow <= 1'b1;
         else if (ovf_clr_c) overflow <= 1'b0;
      end
   end

   // Combinational read mux
   always_comb begin
      Data_in_DM = 8'h00;
      if (is_ram_c) begin
         Data_in_DM = ram[Address_DM];
      end else begin
         case (Address_DM)
            ADDR_OUT_LSB: Data_in_DM = Output_LSB;
            ADDR_OUT_MSB: Data_in_DM = Output_MSB;
            ADDR_KB_DATA: Data_in_DM = fifo_empty_c ? 8'h00 : kb_mem[rd_ptr];
            ADDR_STATUS:  Data_in_DM = {5'b0, fifo_full_c, overflow, !fifo_empty_c};
            default:      Data_in_DM = 8'h00;
         endcase
      end
   end

endmodule
